spi_ram_master: RTL and testbench

Host-side SPI master that sits directly upstream of the SPI slave + RAM wrapper and drives its MOSI/SS_n and samples its MISO. It accepts one RAM command per valid/ready handshake, serialises it as a framed SPI transaction, and for read-data commands captures the 8-bit byte returned on MISO and presents it on a response port. It runs on the same single clock as the slave; no separate SCK is generated, and the slave samples on clk.

---
 rtl/spi_ram_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_ram_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// -----------------------------------------------------------------------------
// spi_ram_master
//
// Host-side SPI master for the single-clock SPI slave + RAM wrapper. It takes
// one RAM command per valid/ready handshake and serialises it as a framed
// transaction on MOSI/SS_n. No separate SCK is generated because the slave
// samples on clk. For read-data commands (op 11), the master waits RD_WAIT
// turnaround cycles. It then captures 8 MISO bits, MSB first, and presents the
// byte on the response port.
//
// Frame on MOSI while SS_n is low:
//   START (1)   : cmd_op[1]
//   SHIFT (10)  : cmd_op[1], cmd_op[0], cmd_data[7..0]
//   TURN        : 0 for RD_WAIT cycles           (op 11 only)
//   CAPTURE (8) : 0, MISO sampled on each edge   (op 11 only)
// SS_n is then held high for GAP_CYCLES before the master returns to IDLE.
//
// Parameters:
//   RD_WAIT    : turnaround cycles before the first MISO sample (1..15)
//   GAP_CYCLES : minimum SS_n-high cycles between frames          (1..15)
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : command request
//   cmd_ready  : command accepted when high together with cmd_valid (IDLE)
//   cmd_op     : 00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   cmd_data   : address/data byte; shifted out even for op 11
//   rsp_valid  : one-cycle pulse when a read byte has been captured
//   rsp_data   : last captured read byte, held until the next capture
//   busy       : high from accept until the inter-frame gap completes
//   MOSI       : serial data to the slave, MSB first
//   SS_n       : active-low slave select
//   MISO       : serial data from the slave
//   frame_cnt  : completed frame count, saturating
//                (present only when SPI_RAM_MASTER_FRAME_CNT_EN is defined)
//
// Optional feature macro: SPI_RAM_MASTER_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module spi_ram_master #(
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        MOSI,
  output logic        SS_n,
  input  logic        MISO
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [3:0] RD_WAIT_M1 = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_M1     = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    TURN,
    CAPTURE,
    GAP
  } state_t;

  state_t      state_q, state_d;
  // The frame register shifts left while SHIFT runs, so frame_q[8] is always
  // the next bit to be driven onto MOSI.
  logic [9:0]  frame_q, frame_d;
  // The op-11 flag is kept separately because the frame register is consumed
  // while it shifts.
  logic        rd_data_q, rd_data_d;
  // One down-counter serves every timed state. Its meaning depends on the
  // state: bit index in SHIFT, remaining cycles in TURN, CAPTURE and GAP.
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        mosi_q, mosi_d;
  logic        ss_n_q, ss_n_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;

  // All outputs are registered. The next-state logic therefore computes the
  // value each output must take during the cycle it is moving into.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    rd_data_d   = rd_data_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    mosi_d      = 1'b0;
    ss_n_d      = ss_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        if (cmd_valid) begin
          state_d     = START;
          frame_d     = {cmd_op, cmd_data};
          rd_data_d   = (cmd_op == 2'b11);
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          ss_n_d      = 1'b0;
          mosi_d      = cmd_op[1];
        end
      end

      START: begin
        state_d = SHIFT;
        cnt_d   = 4'd9;
        ss_n_d  = 1'b0;
        mosi_d  = frame_q[9];
      end

      SHIFT: begin
        ss_n_d = 1'b0;
        if (cnt_q == 4'd0) begin
          if (rd_data_q) begin
            state_d = TURN;
            cnt_d   = RD_WAIT_M1;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_M1;
            ss_n_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q - 4'd1;
          frame_d = {frame_q[8:0], 1'b0};
          mosi_d  = frame_q[8];
        end
      end

      TURN: begin
        ss_n_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = CAPTURE;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      CAPTURE: begin
        ss_n_d  = 1'b0;
        shift_d = {shift_q[6:0], MISO};
        if (cnt_q == 4'd0) begin
          rsp_data_d  = {shift_q[6:0], MISO};
          rsp_valid_d = 1'b1;
          state_d     = GAP;
          cnt_d       = GAP_M1;
          ss_n_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      GAP: begin
        ss_n_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        ss_n_d      = 1'b1;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      rd_data_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rd_data_q   <= rd_data_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign MOSI      = mosi_q;
  assign SS_n      = ss_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // A frame counts as complete on its entry into GAP. A frame cut short by
  // reset never reaches GAP, so it is not counted.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if ((state_d == GAP) && (state_q != GAP) && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_master
//
// Directed bench for spi_ram_master with the default parameters
// (RD_WAIT=2, GAP_CYCLES=1).
//
// A negedge monitor records each SS_n-low frame as a bit string of MOSI
// values. It also drives MISO from miso_byte during the capture window, which
// covers low cycles 13..20 of a read-data frame. It counts rsp_valid pulses
// and the shortest SS_n-high gap between frames.
//
// Expected frame bit strings are written out by hand as
// {cmd_op[1], cmd_op, cmd_data}, followed by zeros for the turnaround and
// capture cycles.
// -----------------------------------------------------------------------------
module tb_spi_ram_master;

  localparam int RD_WAIT    = 2;
  localparam int GAP_CYCLES = 1;
  localparam int CAP0       = 11 + RD_WAIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        MOSI;
  logic        SS_n;
  logic        MISO = 1'b0;
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  spi_ram_master #(.RD_WAIT(RD_WAIT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .MOSI      (MOSI),
    .SS_n      (SS_n),
    .MISO      (MISO)
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;

  // monitor state
  logic [7:0]  miso_byte = 8'h00;
  logic [31:0] cur_bits = '0;
  logic [31:0] last_bits = '0;
  int          cur_len = 0;
  int          last_len = 0;
  int          frames_started = 0;
  int          frames_done = 0;
  int          rsp_count = 0;
  int          hi_len = 1000;
  int          min_gap = 1000;
  bit          in_frame = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        cur_len  = 0;
        cur_bits = '0;
        frames_started++;
        if (hi_len < min_gap) min_gap = hi_len;
      end
      // The value set here is sampled by the rising edge that ends this cycle.
      if (cur_len >= CAP0 && cur_len < CAP0 + 8) MISO = miso_byte[7 - (cur_len - CAP0)];
      else MISO = 1'b0;
      cur_bits = {cur_bits[30:0], MOSI};
      cur_len++;
    end else begin
      MISO = 1'b0;
      if (in_frame) begin
        in_frame  = 1'b0;
        last_len  = cur_len;
        last_bits = cur_bits;
        frames_done++;
        hi_len = 0;
      end
      if (hi_len < 1000) hi_len++;
    end
    if (rsp_valid === 1'b1) rsp_count++;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
    int t = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_data  = ~data;
  endtask

  // Returns #1 after the negedge at which the monitor saw the frame end,
  // which is the first SS_n-high cycle.
  task automatic wait_frame();
    int base = frames_done;
    int t = 0;
    while (frames_done == base && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("frame_timeout", 32'(frames_done), 32'(base + 1));
  endtask

  initial begin
    int base_rsp;
    int base_start;
    int t;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_SS_n", 32'(SS_n), 32'd1);
    chk("rst_MOSI", 32'(MOSI), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h00);
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write address 0x3C: 0,0,0,0,0,1,1,1,1,0,0
    base_rsp = rsp_count;
    send_cmd(2'b00, 8'h3C);
    wait_frame();
    chk("wa3c_len", 32'(last_len), 32'd11);
    chk("wa3c_bits", last_bits, 32'h03C);
    chk("wa3c_gap_busy", 32'(busy), 32'd1);
    chk("wa3c_gap_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); #1;
    chk("wa3c_idle_ready", 32'(cmd_ready), 32'd1);
    chk("wa3c_idle_busy", 32'(busy), 32'd0);
    chk("wa3c_no_rsp", 32'(rsp_count), 32'(base_rsp));

    // write address 0x10, then write data 0xA7 (0,0,1,10100111)
    send_cmd(2'b00, 8'h10);
    wait_frame();
    chk("wa10_bits", last_bits, 32'h010);
    send_cmd(2'b01, 8'hA7);
    wait_frame();
    chk("wda7_len", 32'(last_len), 32'd11);
    chk("wda7_bits", last_bits, 32'h1A7);

    // read address 0x10, then read data returning 0xA7
    send_cmd(2'b10, 8'h10);
    wait_frame();
    chk("ra10_bits", last_bits, 32'h610);
    miso_byte = 8'hA7;
    base_rsp  = rsp_count;
    send_cmd(2'b11, 8'h00);
    wait_frame();
    chk("rd_a7_len", 32'(last_len), 32'd21);
    chk("rd_a7_bits", last_bits, 32'h1C0000);
    chk("rd_a7_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_a7_rsp_data", 32'(rsp_data), 32'hA7);
    @(negedge clk); #1;
    chk("rd_a7_pulse_count", 32'(rsp_count - base_rsp), 32'd1);

    // read data with MISO = 1,0,1,0,0,1,0,1; the content of cmd_data is
    // still shifted out
    miso_byte = 8'hA5;
    send_cmd(2'b11, 8'hFF);
    wait_frame();
    chk("rd_a5_bits", last_bits, 32'h1FFC00);
    chk("rd_a5_rsp_data", 32'(rsp_data), 32'hA5);
    miso_byte = 8'h3C;
    send_cmd(2'b00, 8'h01);
    wait_frame();
    chk("rd_a5_hold", 32'(rsp_data), 32'hA5);

    // reset pulse in the middle of a write-data frame
    base_rsp = rsp_count;
    send_cmd(2'b01, 8'hFF);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_pre_MOSI", 32'(MOSI), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_SS_n", 32'(SS_n), 32'd1);
    chk("abort_MOSI", 32'(MOSI), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_count), 32'(base_rsp));
    send_cmd(2'b00, 8'h5A);
    wait_frame();
    chk("post_abort_len", 32'(last_len), 32'd11);
    chk("post_abort_bits", last_bits, 32'h05A);

    // three write-data commands with cmd_valid held high
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    min_gap    = 1000;
    base_start = frames_started;
    cmd_op     = 2'b01;
    cmd_data   = 8'h3C;
    cmd_valid  = 1'b1;
    t = 0;
    while (frames_started < base_start + 3 && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    if (t >= 300) chk("queue_timeout", 32'(frames_started - base_start), 32'd3);
    wait_frame();
    repeat (6) @(negedge clk);
    #1;
    chk("queue_frames", 32'(frames_started - base_start), 32'd3);
    chk("queue_bits", last_bits, 32'h13C);
    chk("queue_min_gap", 32'(min_gap), 32'(GAP_CYCLES + 1));
    chk("queue_ready", 32'(cmd_ready), 32'd1);
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
    chk("queue_frame_cnt", 32'(frame_cnt), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
